// File: rtl/reg_file_pkg.sv
// Shared constants, address type and flattened-port slicing helper for the
// parametrised register file.
package reg_file_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ZERO_REG     = 0;

  typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;

  // Low bit index of field k in a bus built from equal-width fields.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_file_param_scoreboard.sv
// Busy scoreboard: one bit per register, set at issue and cleared at writeback.
// An issue wins over a writeback to the same register on the same edge.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busyVec
);

  logic [NUM_REGS-1:0] r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy[ZERO_REG] <= 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
        // A new producer replaces the retiring one, so set has priority.
        if (set_en && set_addr == ADDR_W'(r)) begin
          r_busy[r] <= 1'b1;
        end else if (clr_en && clr_addr == ADDR_W'(r)) begin
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  assign busyVec = r_busy;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file with hardwired zero register and RAW busy
// scoreboard. Define REG_FILE_BYPASS_EN for write-through read forwarding.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     regWrite,
  input  logic [ADDR_W-1:0]        writeRegister,
  input  logic [DATA_W-1:0]        writeData,
  input  logic [NUM_RD*ADDR_W-1:0] readRegister,
  output logic [NUM_RD*DATA_W-1:0] readData,
  output logic [NUM_RD-1:0]        readBusy,
  input  logic                     issueValid,
  input  logic [ADDR_W-1:0]        issueRegister,
  output logic [NUM_REGS-1:0]      busyVec
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic                w_wr_en;

  assign w_wr_en = regWrite && (writeRegister != ADDR_W'(ZERO_REG));

  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[writeRegister] <= writeData;
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issueValid),
    .set_addr (issueRegister),
    .clr_en   (regWrite),
    .clr_addr (writeRegister),
    .busyVec  (w_busy)
  );

  assign busyVec = w_busy;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = readRegister[slice_lo(g, ADDR_W) +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
    // Forwarding is gated by rst_n so reads stay zero throughout reset.
    logic w_fwd;
    assign w_fwd = rst_n && w_wr_en && (writeRegister == w_addr);
    assign readData[slice_lo(g, DATA_W) +: DATA_W] = w_fwd ? writeData : r_regs[w_addr];
    assign readBusy[g] = w_fwd ? (issueValid && issueRegister == w_addr) : w_busy[w_addr];
`else
    assign readData[slice_lo(g, DATA_W) +: DATA_W] = r_regs[w_addr];
    assign readBusy[g] = w_busy[w_addr];
`endif
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default 32x32/2-port instance plus a
// 16x64/4-port instance checked against a small reference model.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst_n;

  // Default configuration: DATA_W=32, NUM_REGS=32, NUM_RD=2
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [9:0]  readRegister;
  logic [63:0] readData;
  logic [1:0]  readBusy;
  logic        issueValid;
  logic [4:0]  issueRegister;
  logic [31:0] busyVec;

  // Sweep configuration: DATA_W=64, NUM_REGS=16, NUM_RD=4
  logic         s_regWrite;
  logic [3:0]   s_writeRegister;
  logic [63:0]  s_writeData;
  logic [15:0]  s_readRegister;
  logic [255:0] s_readData;
  logic [3:0]   s_readBusy;
  logic         s_issueValid;
  logic [3:0]   s_issueRegister;
  logic [15:0]  s_busyVec;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_param u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .regWrite      (regWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .readRegister  (readRegister),
    .readData      (readData),
    .readBusy      (readBusy),
    .issueValid    (issueValid),
    .issueRegister (issueRegister),
    .busyVec       (busyVec)
  );

  reg_file_param #(
    .DATA_W   (64),
    .NUM_REGS (16),
    .NUM_RD   (4)
  ) u_sweep (
    .clk           (clk),
    .rst_n         (rst_n),
    .regWrite      (s_regWrite),
    .writeRegister (s_writeRegister),
    .writeData     (s_writeData),
    .readRegister  (s_readRegister),
    .readData      (s_readData),
    .readBusy      (s_readBusy),
    .issueValid    (s_issueValid),
    .issueRegister (s_issueRegister),
    .busyVec       (s_busyVec)
  );

  task automatic idle_inputs();
    regWrite = 1'b0; writeRegister = '0; writeData = '0;
    issueValid = 1'b0; issueRegister = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    readRegister = {5'd5, 5'd5};
    s_regWrite = 1'b0; s_writeRegister = '0; s_writeData = '0;
    s_issueValid = 1'b0; s_issueRegister = '0; s_readRegister = '0;
    #12;
    n_cmp++; if (readData !== 64'h0) begin n_fail++; $display("FAIL reset_readData: got %h expected %h", readData, 64'h0); end
    n_cmp++; if (busyVec !== 32'h0) begin n_fail++; $display("FAIL reset_busyVec: got %h expected %h", busyVec, 32'h0); end
    n_cmp++; if (readBusy !== 2'b00) begin n_fail++; $display("FAIL reset_readBusy: got %b expected %b", readBusy, 2'b00); end
    n_cmp++; if (s_busyVec !== 16'h0) begin n_fail++; $display("FAIL reset_sweep_busyVec: got %h expected %h", s_busyVec, 16'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    regWrite = 1'b1; writeRegister = 5'd5; writeData = 32'hDEADBEEF;
    issueValid = 1'b1; issueRegister = 5'd6;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (readData[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_r5: got %h expected %h", readData[31:0], 32'hDEADBEEF); end
    n_cmp++; if (busyVec !== 32'h0000_0040) begin n_fail++; $display("FAIL busy_r6: got %h expected %h", busyVec, 32'h0000_0040); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (readData !== 64'h0) begin n_fail++; $display("FAIL async_reset_readData: got %h expected %h", readData, 64'h0); end
    n_cmp++; if (busyVec !== 32'h0) begin n_fail++; $display("FAIL async_reset_busyVec: got %h expected %h", busyVec, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    regWrite = 1'b1; writeRegister = 5'd0; writeData = 32'hFFFFFFFF;
    readRegister = {5'd0, 5'd0};
    #1;
    n_cmp++; if (readData !== 64'h0) begin n_fail++; $display("FAIL zero_same_cycle: got %h expected %h", readData, 64'h0); end
    @(negedge clk);
    idle_inputs();
    issueValid = 1'b1; issueRegister = 5'd0;
    #1;
    n_cmp++; if (readData !== 64'h0) begin n_fail++; $display("FAIL zero_after_write: got %h expected %h", readData, 64'h0); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (busyVec[0] !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected %b", busyVec[0], 1'b0); end
    n_cmp++; if (readBusy !== 2'b00) begin n_fail++; $display("FAIL zero_readBusy: got %b expected %b", readBusy, 2'b00); end
  endtask

  task automatic test_write_read();
    logic [63:0] exp_now;
`ifdef REG_FILE_BYPASS_EN
    exp_now = {32'h12345678, 32'h12345678};
`else
    exp_now = 64'h0;
`endif
    @(negedge clk);
    regWrite = 1'b1; writeRegister = 5'd7; writeData = 32'h12345678;
    readRegister = {5'd7, 5'd7};
    #1;
    n_cmp++; if (readData !== exp_now) begin n_fail++; $display("FAIL wr_same_cycle: got %h expected %h", readData, exp_now); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (readData !== {32'h12345678, 32'h12345678}) begin n_fail++; $display("FAIL wr_next_cycle: got %h expected %h", readData, {32'h12345678, 32'h12345678}); end
  endtask

  task automatic test_scoreboard();
    logic exp_b;
    @(negedge clk);
    issueValid = 1'b1; issueRegister = 5'd3;
    readRegister = {5'd7, 5'd3};
    #1;
    n_cmp++; if (readBusy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_before_issue: got %b expected %b", readBusy[0], 1'b0); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      n_cmp++; if (readBusy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_busy_cycle%0d: got %b expected %b", i, readBusy[0], 1'b1); end
      n_cmp++; if (busyVec !== 32'h0000_0008) begin n_fail++; $display("FAIL sb_busyVec_cycle%0d: got %h expected %h", i, busyVec, 32'h0000_0008); end
    end
    regWrite = 1'b1; writeRegister = 5'd3; writeData = 32'h000000A5;
`ifdef REG_FILE_BYPASS_EN
    exp_b = 1'b0;
`else
    exp_b = 1'b1;
`endif
    #1;
    n_cmp++; if (readBusy[0] !== exp_b) begin n_fail++; $display("FAIL sb_write_cycle: got %b expected %b", readBusy[0], exp_b); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (readBusy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_cleared: got %b expected %b", readBusy[0], 1'b0); end
    n_cmp++; if (readData[31:0] !== 32'h000000A5) begin n_fail++; $display("FAIL sb_r3_data: got %h expected %h", readData[31:0], 32'h000000A5); end
    n_cmp++; if (busyVec !== 32'h0) begin n_fail++; $display("FAIL sb_busyVec_clear: got %h expected %h", busyVec, 32'h0); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    regWrite = 1'b1; writeRegister = 5'd9; writeData = 32'h00000055;
    issueValid = 1'b1; issueRegister = 5'd9;
    readRegister = {5'd4, 5'd9};
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (readData[31:0] !== 32'h00000055) begin n_fail++; $display("FAIL simul_r9_data: got %h expected %h", readData[31:0], 32'h00000055); end
    n_cmp++; if (busyVec[9] !== 1'b1) begin n_fail++; $display("FAIL simul_busy9: got %b expected %b", busyVec[9], 1'b1); end
    regWrite = 1'b1; writeRegister = 5'd9; writeData = 32'h00000066;
    issueValid = 1'b1; issueRegister = 5'd4;
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (busyVec !== 32'h0000_0010) begin n_fail++; $display("FAIL split_busyVec: got %h expected %h", busyVec, 32'h0000_0010); end
    n_cmp++; if (readBusy !== 2'b10) begin n_fail++; $display("FAIL split_readBusy: got %b expected %b", readBusy, 2'b10); end
    n_cmp++; if (readData[31:0] !== 32'h00000066) begin n_fail++; $display("FAIL split_r9_data: got %h expected %h", readData[31:0], 32'h00000066); end
    // Re-issue to busy r4 and writeback to idle r9.
    issueValid = 1'b1; issueRegister = 5'd4;
    regWrite = 1'b1; writeRegister = 5'd9; writeData = 32'h00000077;
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (busyVec !== 32'h0000_0010) begin n_fail++; $display("FAIL reissue_busyVec: got %h expected %h", busyVec, 32'h0000_0010); end
    n_cmp++; if (readData[31:0] !== 32'h00000077) begin n_fail++; $display("FAIL idle_wb_data: got %h expected %h", readData[31:0], 32'h00000077); end
  endtask

  task automatic test_sweep();
    logic [63:0] m_regs [16];
    logic [15:0] m_busy;
    logic [3:0]  ra;
    logic [63:0] exp_d;
    logic        exp_b;
    for (int r = 0; r < 16; r++) m_regs[r] = '0;
    m_busy = '0;
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      s_regWrite      = ($urandom_range(0, 2) != 0);
      s_writeRegister = 4'($urandom_range(0, 15));
      s_writeData     = {$urandom, $urandom};
      s_issueValid    = ($urandom_range(0, 1) != 0);
      s_issueRegister = 4'($urandom_range(0, 15));
      if (it % 5 == 0) begin
        ra = s_writeRegister;
        s_readRegister = {ra, ra, ra, ra};
      end else begin
        s_readRegister = 16'($urandom);
      end
      #1;
      for (int k = 0; k < 4; k++) begin
        ra = s_readRegister[k*4 +: 4];
        exp_d = (ra == 4'd0) ? 64'h0 : m_regs[ra];
        exp_b = m_busy[ra];
`ifdef REG_FILE_BYPASS_EN
        if (s_regWrite && s_writeRegister == ra && ra != 4'd0) begin
          exp_d = s_writeData;
          exp_b = s_issueValid && (s_issueRegister == ra);
        end
`endif
        n_cmp++; if (s_readData[k*64 +: 64] !== exp_d) begin n_fail++; $display("FAIL sweep_data it%0d port%0d: got %h expected %h", it, k, s_readData[k*64 +: 64], exp_d); end
        n_cmp++; if (s_readBusy[k] !== exp_b) begin n_fail++; $display("FAIL sweep_busy it%0d port%0d: got %b expected %b", it, k, s_readBusy[k], exp_b); end
      end
      n_cmp++; if (s_busyVec !== m_busy) begin n_fail++; $display("FAIL sweep_busyVec it%0d: got %h expected %h", it, s_busyVec, m_busy); end
      @(posedge clk);
      if (s_regWrite) begin
        if (s_writeRegister != 4'd0) m_regs[s_writeRegister] = s_writeData;
        m_busy[s_writeRegister] = 1'b0;
      end
      if (s_issueValid && s_issueRegister != 4'd0) m_busy[s_issueRegister] = 1'b1;
    end
    @(negedge clk);
    s_regWrite = 1'b0; s_issueValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_write_read();
    test_scoreboard();
    test_simultaneous();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
